arith_dispatcher: RTL and testbench
===================================

Name: arith_dispatcher

Overview:
- Issue-side controller for the combinational arithmetic unit.
- Accepts one arithmetic request at a time over a valid/ready interface from decode. Registers opcode and operands onto the arithmetic unit's inputs, captures its 19-bit result one cycle later, and returns the result with its destination tag over a valid/ready response interface to writeback.
- Screens divide-by-zero and unsupported opcodes before the result is returned.

Parameters:
- WORD_SIZE, 19, operand/result width (matches constants package)
- OPCODE_SIZE, 5, opcode width (matches constants package)
- DEST_W, 4, destination register tag width
- CNT_W, 16, completed-operation counter width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  dispatcher can accept request
- req_opcode  in  OPCODE_SIZE  one of ADD, SUB, MUL, DIV, INC, DEC (opcodes package)
- req_op1  in  WORD_SIZE  operand 1
- req_op2  in  WORD_SIZE  operand 2 (ignored for INC/DEC)
- req_dest  in  DEST_W  destination tag
- au_opcode  out  OPCODE_SIZE  registered opcode to arithmetic unit
- au_operand_1  out  WORD_SIZE  registered operand 1 to arithmetic unit
- au_operand_2  out  WORD_SIZE  registered operand 2 to arithmetic unit
- au_result  in  WORD_SIZE  combinational result from arithmetic unit
- rsp_valid  out  1  response present
- rsp_ready  in  1  writeback accepts response
- rsp_result  out  WORD_SIZE  final result
- rsp_dest  out  DEST_W  echoed destination tag
- rsp_dz  out  1  DIV with op2==0
- rsp_illegal  out  1  opcode not in supported set
- done_count  out  CNT_W  responses handed off, wraps modulo 2^CNT_W

Behaviour:
- States: IDLE, EXEC, RESP.
  - Reset enters IDLE.
  - All outputs reset to 0: au_*, rsp_*, done_count.
- req_ready = (state==IDLE) | (state==RESP & rsp_ready). This is combinational from rsp_ready, and req_ready never depends on req_valid.
- Accept (req_valid & req_ready) in cycle N:
  - au_opcode, au_operand_1 and au_operand_2 are loaded at the edge ending N.
  - au_operand_2 is loaded as 0 for INC/DEC.
  - req_dest is latched and the state moves to EXEC.
- EXEC (cycle N+1), result capture at the edge ending N+1:
  - Normal case: rsp_result=au_result.
  - DIV & op2==0: rsp_result=all ones, rsp_dz=1, au_result ignored.
  - Unsupported opcode: rsp_result=0, rsp_illegal=1.
  - rsp_valid=1 and the state moves to RESP. Request-to-response latency is therefore 2 cycles.
- RESP:
  - rsp_result, rsp_dest, rsp_dz and rsp_illegal are held stable while rsp_valid & !rsp_ready.
  - On handshake: done_count increments and rsp_valid drops.
  - If a new request is accepted in the same cycle, the state goes to EXEC. Otherwise it goes to IDLE.
  - Sustained throughput is one operation per 2 cycles.
- au_* hold their last issued values in RESP/IDLE. Only an accept changes them.
- rsp_dz and rsp_illegal are mutually exclusive and are cleared on every capture.
- Arithmetic wraps modulo 2^WORD_SIZE (overflow is the arithmetic unit's behaviour). The dispatcher adds no flags for overflow.
- done_count wraps from 2^CNT_W-1 to 0.
- Reset asserted in any state:
  - The in-flight operation is dropped with no response and the state goes to IDLE.
  - req_ready goes high on the first edge after rst_n deasserts.
- req_valid in EXEC is ignored (req_ready=0). Upstream must hold its request per the handshake rules.

Test Plan:
- ADD op1=0x7FFFF op2=0x00001 dest=3 accepted cycle N -> rsp_valid at N+2, rsp_result=0x00000, rsp_dest=3, flags 0.
- SUB 5-7, then MUL 0x00300*0x00200 back-to-back with rsp_ready=1 -> results 0x7FFFE then 0x60000. Second req_ready is high in the RESP cycle of the first, and the responses are 2 cycles apart. done_count=2.
- DIV 100/7 -> 0x0000E. DIV 100/0 -> rsp_result=0x7FFFF, rsp_dz=1, rsp_illegal=0.
- INC op1=0x7FFFF op2=0x12345 -> au_operand_2=0 in EXEC, rsp_result=0x00000. Unsupported opcode -> rsp_result=0, rsp_illegal=1.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, req_ready=0, done_count unchanged. Releasing rsp_ready gives exactly one increment.
- rst_n pulsed low during EXEC -> no rsp_valid, all outputs 0 asynchronously, req_ready=1 the cycle after release. done_count is preset near max and wraps 0xFFFF->0x0000.

Source files
------------

// File: rtl/arith_dispatcher.sv
// Issue-side controller for the combinational arithmetic unit: registers one request onto
// the unit's inputs, captures its result a cycle later and hands it to writeback.
module arith_dispatcher #(
  parameter int WORD_SIZE   = 19,
  parameter int OPCODE_SIZE = 5,
  parameter int DEST_W      = 4,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [OPCODE_SIZE-1:0] req_opcode,
  input  logic [WORD_SIZE-1:0]   req_op1,
  input  logic [WORD_SIZE-1:0]   req_op2,
  input  logic [DEST_W-1:0]      req_dest,
  output logic [OPCODE_SIZE-1:0] au_opcode,
  output logic [WORD_SIZE-1:0]   au_operand_1,
  output logic [WORD_SIZE-1:0]   au_operand_2,
  input  logic [WORD_SIZE-1:0]   au_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WORD_SIZE-1:0]   rsp_result,
  output logic [DEST_W-1:0]      rsp_dest,
  output logic                   rsp_dz,
  output logic                   rsp_illegal,
  output logic [CNT_W-1:0]       done_count,
  output logic [1:0]             dbg_state
);

  localparam logic [OPCODE_SIZE-1:0] OP_ADD = OPCODE_SIZE'(0);
  localparam logic [OPCODE_SIZE-1:0] OP_SUB = OPCODE_SIZE'(1);
  localparam logic [OPCODE_SIZE-1:0] OP_MUL = OPCODE_SIZE'(2);
  localparam logic [OPCODE_SIZE-1:0] OP_DIV = OPCODE_SIZE'(3);
  localparam logic [OPCODE_SIZE-1:0] OP_INC = OPCODE_SIZE'(4);
  localparam logic [OPCODE_SIZE-1:0] OP_DEC = OPCODE_SIZE'(5);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]           state;
  logic [DEST_W-1:0]    dest_q;
  logic                 accept;
  logic                 rsp_hs;
  logic                 op_legal;
  logic                 div_zero;
  logic [WORD_SIZE-1:0] next_result;

  // Handshake: a transfer happens on any rising edge where valid and ready are both high.
  // Requests may be accepted in the same cycle the previous response is taken.
  assign req_ready = (state == IDLE) | ((state == RESP) & rsp_ready);
  assign accept    = req_valid & req_ready;
  assign rsp_hs    = rsp_valid & rsp_ready;
  assign dbg_state = state;

  always_comb begin
    op_legal = 1'b0;
    case (au_opcode)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_INC, OP_DEC: op_legal = 1'b1;
      default:                                        op_legal = 1'b0;
    endcase
    div_zero    = op_legal & (au_opcode == OP_DIV) & (au_operand_2 == '0);
    next_result = au_result;
    if (!op_legal) begin
      next_result = '0;
    end else if (div_zero) begin
      next_result = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dest_q       <= '0;
      au_opcode    <= '0;
      au_operand_1 <= '0;
      au_operand_2 <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_dest     <= '0;
      rsp_dz       <= 1'b0;
      rsp_illegal  <= 1'b0;
      done_count   <= '0;
    end else begin
      case (state)
        IDLE:    if (accept) state <= EXEC;
        EXEC:    state <= RESP;
        RESP:    if (rsp_hs) state <= accept ? EXEC : IDLE;
        default: state <= IDLE;
      endcase

      if (accept) begin
        au_opcode    <= req_opcode;
        au_operand_1 <= req_op1;
        // INC/DEC are unary; keep the unused operand at zero on the unit's input.
        au_operand_2 <= ((req_opcode == OP_INC) || (req_opcode == OP_DEC)) ? '0 : req_op2;
        dest_q       <= req_dest;
      end

      if (state == EXEC) begin
        rsp_valid   <= 1'b1;
        rsp_result  <= next_result;
        rsp_dest    <= dest_q;
        rsp_dz      <= div_zero;
        rsp_illegal <= ~op_legal;
      end else if (rsp_hs) begin
        rsp_valid  <= 1'b0;
        done_count <= done_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_arith_dispatcher.sv
// Directed bench for arith_dispatcher with a behavioural model of the arithmetic unit.
module tb_arith_dispatcher;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_MUL = 5'd2;
  localparam logic [4:0] OP_DIV = 5'd3;
  localparam logic [4:0] OP_INC = 5'd4;
  localparam logic [4:0] OP_DEC = 5'd5;
  localparam logic [4:0] OP_BAD = 5'd31;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_opcode;
  logic [18:0] req_op1;
  logic [18:0] req_op2;
  logic [3:0]  req_dest;
  logic [4:0]  au_opcode;
  logic [18:0] au_operand_1;
  logic [18:0] au_operand_2;
  logic [18:0] au_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [18:0] rsp_result;
  logic [3:0]  rsp_dest;
  logic        rsp_dz;
  logic        rsp_illegal;
  logic [15:0] done_count;
  logic [1:0]  dbg_state;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_cnt  = '0;

  arith_dispatcher dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_op1(req_op1), .req_op2(req_op2), .req_dest(req_dest),
    .au_opcode(au_opcode), .au_operand_1(au_operand_1), .au_operand_2(au_operand_2),
    .au_result(au_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_dest(rsp_dest), .rsp_dz(rsp_dz), .rsp_illegal(rsp_illegal),
    .done_count(done_count), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic unit: junk values on divide-by-zero and bad opcodes expose missing overrides.
  always_comb begin
    au_result = 19'h2AAAA;
    case (au_opcode)
      OP_ADD: au_result = au_operand_1 + au_operand_2;
      OP_SUB: au_result = au_operand_1 - au_operand_2;
      OP_MUL: au_result = au_operand_1 * au_operand_2;
      OP_DIV: au_result = (au_operand_2 == 0) ? 19'h01234 : au_operand_1 / au_operand_2;
      OP_INC: au_result = au_operand_1 + 19'd1;
      OP_DEC: au_result = au_operand_1 - 19'd1;
      default: au_result = 19'h2AAAA;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it to the response cycle (rsp_valid just asserted).
  task automatic run_op(input string tag, input logic [4:0] op, input logic [18:0] a,
                        input logic [18:0] b, input logic [3:0] d, input logic [18:0] exp_res,
                        input logic exp_dz, input logic exp_ill);
    int n;
    req_opcode = op; req_op1 = a; req_op2 = b; req_dest = d; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, " accept_timeout"}, 32'(n < 20), 32'd1);
    tick();
    req_valid = 1'b0;
    check({tag, " exec_state"}, 32'(dbg_state), 32'd1);
    check({tag, " exec_no_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " au_opcode"}, 32'(au_opcode), 32'(op));
    check({tag, " au_operand_2"}, 32'(au_operand_2),
          32'(((op == OP_INC) || (op == OP_DEC)) ? 19'd0 : b));
    tick();
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " rsp_result"}, 32'(rsp_result), 32'(exp_res));
    check({tag, " rsp_dest"}, 32'(rsp_dest), 32'(d));
    check({tag, " rsp_dz"}, 32'(rsp_dz), 32'(exp_dz));
    check({tag, " rsp_illegal"}, 32'(rsp_illegal), 32'(exp_ill));
  endtask

  task automatic finish_hs(input string tag);
    rsp_ready = 1'b1;
    tick();
    exp_cnt = exp_cnt + 16'd1;
    check({tag, " hs_valid_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, " done_count"}, 32'(done_count), 32'(exp_cnt));
  endtask

  initial begin
    logic [15:0] base;
    rst_n = 1'b0; req_valid = 1'b0; req_opcode = '0; req_op1 = '0; req_op2 = '0;
    req_dest = '0; rsp_ready = 1'b1;
    repeat (2) tick();
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset au_operand_1", 32'(au_operand_1), 32'd0);
    check("reset done_count", 32'(done_count), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_reset req_ready", 32'(req_ready), 32'd1);

    run_op("add_wrap", OP_ADD, 19'h7FFFF, 19'h00001, 4'd3, 19'h00000, 1'b0, 1'b0);
    finish_hs("add_wrap");

    // Back-to-back SUB then MUL: second request taken in the first one's RESP cycle.
    base = done_count;
    run_op("sub", OP_SUB, 19'd5, 19'd7, 4'd1, 19'h7FFFE, 1'b0, 1'b0);
    req_opcode = OP_MUL; req_op1 = 19'h00300; req_op2 = 19'h00200; req_dest = 4'd2;
    req_valid = 1'b1;
    #1;
    check("b2b req_ready_in_resp", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    check("b2b first_hs", 32'(rsp_valid), 32'd0);
    check("b2b mul_issued", 32'(au_opcode), 32'(OP_MUL));
    tick();
    check("b2b mul_valid", 32'(rsp_valid), 32'd1);
    check("b2b mul_result", 32'(rsp_result), 32'h60000);
    check("b2b mul_dest", 32'(rsp_dest), 32'd2);
    finish_hs("b2b");
    check("b2b count_delta", 32'(done_count - base), 32'd2);

    run_op("div", OP_DIV, 19'd100, 19'd7, 4'd4, 19'h0000E, 1'b0, 1'b0);
    finish_hs("div");
    run_op("div_zero", OP_DIV, 19'd100, 19'd0, 4'd5, 19'h7FFFF, 1'b1, 1'b0);
    finish_hs("div_zero");
    run_op("inc", OP_INC, 19'h7FFFF, 19'h12345, 4'd6, 19'h00000, 1'b0, 1'b0);
    finish_hs("inc");
    run_op("illegal", OP_BAD, 19'h00042, 19'h00003, 4'd7, 19'h00000, 1'b0, 1'b1);
    finish_hs("illegal");

    // Backpressure: response must hold while writeback stalls.
    rsp_ready = 1'b0;
    run_op("bp", OP_DEC, 19'h00010, 19'h00abc, 4'd9, 19'h0000F, 1'b0, 1'b0);
    req_opcode = OP_ADD; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp hold_valid", 32'(rsp_valid), 32'd1);
      check("bp hold_result", 32'(rsp_result), 32'h0000F);
      check("bp hold_dest", 32'(rsp_dest), 32'd9);
      check("bp req_ready", 32'(req_ready), 32'd0);
      check("bp count_hold", 32'(done_count), 32'(exp_cnt));
    end
    req_valid = 1'b0;
    finish_hs("bp");
    tick();
    check("bp single_increment", 32'(done_count), 32'(exp_cnt));

    // Reset during EXEC drops the operation.
    req_opcode = OP_ADD; req_op1 = 19'h12345; req_op2 = 19'h00011; req_dest = 4'd8;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("rst exec_state", 32'(dbg_state), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst async_au_opcode", 32'(au_opcode), 32'd0);
    check("rst async_au_operand_1", 32'(au_operand_1), 32'd0);
    check("rst async_au_operand_2", 32'(au_operand_2), 32'd0);
    check("rst async_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst async_done_count", 32'(done_count), 32'd0);
    exp_cnt = '0;
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("rst req_ready_after", 32'(req_ready), 32'd1);
    check("rst no_response", 32'(rsp_valid), 32'd0);
    tick();
    check("rst still_no_response", 32'(rsp_valid), 32'd0);

    // Counter wrap from a preset near max.
    force dut.done_count = 16'hFFFF;
    #1;
    release dut.done_count;
    #1;
    check("wrap preset", 32'(done_count), 32'h0000FFFF);
    exp_cnt = 16'hFFFF;
    run_op("wrap_op", OP_ADD, 19'd1, 19'd2, 4'd10, 19'd3, 1'b0, 1'b0);
    finish_hs("wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
